branch_predictor: RTL and testbench

Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- **Fetch side:** looks up the fetch PC and supplies a predicted next PC.
- **Execute side:** consumes the resolved branch outcome from the execute-stage conditional logic (its branch-taken write enable).
- **Outputs to hazard/PC logic:** a mispredict flag and a redirect PC.
- **Statistics:** saturating branch and mispredict counters for performance measurement.

---
 rtl/branch_predictor.sv | 99 +++++++++
 tb/tb_branch_predictor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, execute-side resolution,
// mispredict/redirect generation and saturating performance counters.
module branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          PCF,
    output logic                 PredTakenF,
    output logic [31:0]          PredTargetF,
    input  logic                 BranchE,
    input  logic                 TakenE,
    input  logic [31:0]          PCE,
    input  logic [31:0]          TargetE,
    input  logic                 PredTakenE,
    input  logic [31:0]          PredTargetE,
    input  logic                 FlushE,
    output logic                 MispredictE,
    output logic [31:0]          RedirectPCE,
    output logic [CNT_WIDTH-1:0] BranchCnt,
    output logic [CNT_WIDTH-1:0] MissCnt
);
    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 32 - INDEX_BITS - 2;

    logic [ENTRIES-1:0]  valid;
    logic [TAG_BITS-1:0] tag    [ENTRIES];
    logic [31:0]         target [ENTRIES];
    logic [1:0]          ctr    [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f;
    logic [INDEX_BITS-1:0] idx_e;
    logic                  hit_f;
    logic                  hit_e;
    logic                  resolve;

    always_comb begin
        idx_f       = PCF[INDEX_BITS+1:2];
        hit_f       = valid[idx_f] && (tag[idx_f] == PCF[31:INDEX_BITS+2]);
        PredTakenF  = hit_f && ctr[idx_f][1];
        PredTargetF = PredTakenF ? target[idx_f] : PCF + 32'd4;
    end

    always_comb begin
        idx_e   = PCE[INDEX_BITS+1:2];
        hit_e   = valid[idx_e] && (tag[idx_e] == PCE[31:INDEX_BITS+2]);
        resolve = BranchE && !FlushE;
    end

    // A predicted-taken non-branch means the entry is stale: fall through.
    always_comb begin
        MispredictE = 1'b0;
        if (!FlushE) begin
            if (BranchE)
                MispredictE = (PredTakenE != TakenE) ||
                              (TakenE && PredTakenE && (PredTargetE != TargetE));
            else
                MispredictE = PredTakenE;
        end
        RedirectPCE = (BranchE && TakenE) ? TargetE : PCE + 32'd4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= '0;
            tag    <= '{default: '0};
            target <= '{default: '0};
            ctr    <= '{default: 2'b01};
        end else if (resolve) begin
            if (hit_e) begin
                if (TakenE) begin
                    if (ctr[idx_e] != 2'b11)
                        ctr[idx_e] <= ctr[idx_e] + 2'b01;
                    target[idx_e] <= TargetE;
                end else if (ctr[idx_e] != 2'b00) begin
                    ctr[idx_e] <= ctr[idx_e] - 2'b01;
                end
            end else if (TakenE) begin
                valid[idx_e]  <= 1'b1;
                tag[idx_e]    <= PCE[31:INDEX_BITS+2];
                target[idx_e] <= TargetE;
                ctr[idx_e]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            BranchCnt <= '0;
            MissCnt   <= '0;
        end else begin
            if (resolve && (BranchCnt != '1))
                BranchCnt <= BranchCnt + CNT_WIDTH'(1);
            if (MispredictE && (MissCnt != '1))
                MissCnt <= MissCnt + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: one task per scenario, inline checks.
module tb_branch_predictor;
    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        BranchE;
    logic        TakenE;
    logic [31:0] PCE;
    logic [31:0] TargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        FlushE;
    logic        MispredictE;
    logic [31:0] RedirectPCE;
    logic [15:0] BranchCnt;
    logic [15:0] MissCnt;

    logic        sat_pred_taken;
    logic [31:0] sat_pred_target;
    logic        sat_mispredict;
    logic [31:0] sat_redirect;
    logic [1:0]  sat_branch_cnt;
    logic [1:0]  sat_miss_cnt;

    int errors;
    int checks;
    int exp_br;
    int exp_miss;

    branch_predictor #(.INDEX_BITS(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .PCF(PCF),
        .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .BranchE(BranchE), .TakenE(TakenE), .PCE(PCE), .TargetE(TargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .FlushE(FlushE),
        .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
        .BranchCnt(BranchCnt), .MissCnt(MissCnt)
    );

    // Narrow counters so saturation is reachable in a few cycles.
    branch_predictor #(.INDEX_BITS(4), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .PCF(PCF),
        .PredTakenF(sat_pred_taken), .PredTargetF(sat_pred_target),
        .BranchE(BranchE), .TakenE(TakenE), .PCE(PCE), .TargetE(TargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .FlushE(FlushE),
        .MispredictE(sat_mispredict), .RedirectPCE(sat_redirect),
        .BranchCnt(sat_branch_cnt), .MissCnt(sat_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        BranchE     = 1'b0;
        TakenE      = 1'b0;
        FlushE      = 1'b0;
        PredTakenE  = 1'b0;
        PredTargetE = 32'h0;
        PCE         = 32'h0;
        TargetE     = 32'h0;
    endtask

    task automatic resolve(input logic taken, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ptgt);
        BranchE     = 1'b1;
        FlushE      = 1'b0;
        TakenE      = taken;
        PCE         = pc;
        TargetE     = tgt;
        PredTakenE  = ptaken;
        PredTargetE = ptgt;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        PCF = 32'h100;
        #12;
        checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b want 0", PredTakenF); end
        checks++; if (PredTargetF !== 32'h104) begin errors++; $display("FAIL reset_pred_target: got %h want 00000104", PredTargetF); end
        checks++; if (BranchCnt !== 16'h0 || MissCnt !== 16'h0) begin errors++; $display("FAIL reset_counters: got %h/%h want 0/0", BranchCnt, MissCnt); end
        rst = 1'b1;
        tick();
        resolve(1'b1, 32'h100, 32'h200, 1'b0, 32'h0);
        tick();
        drive_idle();
        #1;
        checks++; if (PredTakenF !== 1'b1 || BranchCnt !== 16'd1 || MissCnt !== 16'd1) begin errors++; $display("FAIL reset_precondition: got taken=%b br=%0d miss=%0d want 1/1/1", PredTakenF, BranchCnt, MissCnt); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin errors++; $display("FAIL reset_async_lookup: got %b %h want 0 00000104", PredTakenF, PredTargetF); end
        checks++; if (BranchCnt !== 16'h0 || MissCnt !== 16'h0) begin errors++; $display("FAIL reset_async_counters: got %h/%h want 0/0", BranchCnt, MissCnt); end
        PCF = 32'h3C;
        #1;
        checks++; if (PredTargetF !== 32'h40) begin errors++; $display("FAIL reset_other_pc: got %h want 00000040", PredTargetF); end
        rst = 1'b1;
        tick();
        exp_br   = 0;
        exp_miss = 0;
    endtask

    task automatic test_cold_miss();
        resolve(1'b1, 32'h100, 32'h200, 1'b0, 32'h0);
        PCF = 32'h100;
        #1;
        checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL cold_mispredict: got %b want 1", MispredictE); end
        checks++; if (RedirectPCE !== 32'h200) begin errors++; $display("FAIL cold_redirect: got %h want 00000200", RedirectPCE); end
        checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL cold_no_bypass: got %b want 0", PredTakenF); end
        tick();
        drive_idle();
        exp_br++; exp_miss++;
        #1;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h200) begin errors++; $display("FAIL cold_lookup: got %b %h want 1 00000200", PredTakenF, PredTargetF); end
        checks++; if (BranchCnt !== 16'(exp_br) || MissCnt !== 16'(exp_miss)) begin errors++; $display("FAIL cold_counters: got %0d/%0d want %0d/%0d", BranchCnt, MissCnt, exp_br, exp_miss); end
    endtask

    task automatic test_hysteresis();
        // ctr 10 -> 01
        resolve(1'b0, 32'h100, 32'h200, 1'b1, 32'h200);
        #1;
        checks++; if (MispredictE !== 1'b1 || RedirectPCE !== 32'h104) begin errors++; $display("FAIL hyst_nt1: got %b %h want 1 00000104", MispredictE, RedirectPCE); end
        tick(); drive_idle(); exp_br++; exp_miss++;
        #1;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin errors++; $display("FAIL hyst_ctr01: got %b %h want 0 00000104", PredTakenF, PredTargetF); end
        // 01 -> 00 -> 00
        resolve(1'b0, 32'h100, 32'h200, 1'b0, 32'h0);
        #1;
        checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL hyst_nt2: got %b want 0", MispredictE); end
        tick(); exp_br++;
        tick(); exp_br++;
        // 00 -> 01 (would read taken if 00 had wrapped)
        resolve(1'b1, 32'h100, 32'h200, 1'b0, 32'h0);
        #1;
        checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL hyst_t1: got %b want 1", MispredictE); end
        tick(); drive_idle(); exp_br++; exp_miss++;
        #1;
        checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL hyst_floor: got %b want 0", PredTakenF); end
        resolve(1'b1, 32'h100, 32'h200, 1'b0, 32'h0);
        tick(); drive_idle(); exp_br++; exp_miss++;
        #1;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h200) begin errors++; $display("FAIL hyst_ctr10: got %b %h want 1 00000200", PredTakenF, PredTargetF); end
        // 10 -> 11 -> 11, correctly predicted
        resolve(1'b1, 32'h100, 32'h200, 1'b1, 32'h200);
        #1;
        checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL hyst_correct: got %b want 0", MispredictE); end
        tick(); exp_br++;
        tick(); exp_br++;
        // taken, wrong target: redirect and retarget
        resolve(1'b1, 32'h100, 32'h300, 1'b1, 32'h200);
        #1;
        checks++; if (MispredictE !== 1'b1 || RedirectPCE !== 32'h300) begin errors++; $display("FAIL hyst_wrong_target: got %b %h want 1 00000300", MispredictE, RedirectPCE); end
        tick(); drive_idle(); exp_br++; exp_miss++;
        #1;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h300) begin errors++; $display("FAIL hyst_retarget: got %b %h want 1 00000300", PredTakenF, PredTargetF); end
        // 11 -> 10 still taken proves saturation at 11
        resolve(1'b0, 32'h100, 32'h300, 1'b1, 32'h300);
        tick(); drive_idle(); exp_br++; exp_miss++;
        #1;
        checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL hyst_ceiling: got %b want 1", PredTakenF); end
        resolve(1'b0, 32'h100, 32'h300, 1'b1, 32'h300);
        tick(); drive_idle(); exp_br++; exp_miss++;
        #1;
        checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL hyst_back_to_01: got %b want 0", PredTakenF); end
        checks++; if (BranchCnt !== 16'(exp_br) || MissCnt !== 16'(exp_miss)) begin errors++; $display("FAIL hyst_counters: got %0d/%0d want %0d/%0d", BranchCnt, MissCnt, exp_br, exp_miss); end
    endtask

    task automatic test_aliasing();
        PCF = 32'h140;
        #1;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h144) begin errors++; $display("FAIL alias_premiss: got %b %h want 0 00000144", PredTakenF, PredTargetF); end
        resolve(1'b1, 32'h140, 32'h500, 1'b0, 32'h0);
        #1;
        checks++; if (MispredictE !== 1'b1 || RedirectPCE !== 32'h500) begin errors++; $display("FAIL alias_mispredict: got %b %h want 1 00000500", MispredictE, RedirectPCE); end
        tick(); drive_idle(); exp_br++; exp_miss++;
        PCF = 32'h100;
        #1;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin errors++; $display("FAIL alias_old_evicted: got %b %h want 0 00000104", PredTakenF, PredTargetF); end
        PCF = 32'h140;
        #1;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h500) begin errors++; $display("FAIL alias_new_hit: got %b %h want 1 00000500", PredTakenF, PredTargetF); end
        // not-taken miss must not allocate
        resolve(1'b0, 32'h180, 32'h700, 1'b0, 32'h0);
        #1;
        checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL alias_nt_miss: got %b want 0", MispredictE); end
        tick(); drive_idle(); exp_br++;
        PCF = 32'h140;
        #1;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h500) begin errors++; $display("FAIL alias_kept: got %b %h want 1 00000500", PredTakenF, PredTargetF); end
        PCF = 32'h180;
        #1;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h184) begin errors++; $display("FAIL alias_no_alloc: got %b %h want 0 00000184", PredTakenF, PredTargetF); end
    endtask

    task automatic test_flush_stale();
        resolve(1'b1, 32'h244, 32'h600, 1'b0, 32'h0);
        FlushE = 1'b1;
        PCF    = 32'h244;
        #1;
        checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL flush_mispredict: got %b want 0", MispredictE); end
        tick(); drive_idle();
        #1;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h248) begin errors++; $display("FAIL flush_no_update: got %b %h want 0 00000248", PredTakenF, PredTargetF); end
        FlushE     = 1'b1;
        PredTakenE = 1'b1;
        PCE        = 32'h80;
        #1;
        checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL flush_stale: got %b want 0", MispredictE); end
        tick(); drive_idle();
        #1;
        checks++; if (BranchCnt !== 16'(exp_br) || MissCnt !== 16'(exp_miss)) begin errors++; $display("FAIL flush_counters: got %0d/%0d want %0d/%0d", BranchCnt, MissCnt, exp_br, exp_miss); end
        // stale: TakenE without BranchE must not select TargetE
        PredTakenE = 1'b1;
        TakenE     = 1'b1;
        TargetE    = 32'h900;
        PCE        = 32'hFFFF_FFFC;
        PCF        = 32'hFFFF_FFFC;
        #1;
        checks++; if (MispredictE !== 1'b1 || RedirectPCE !== 32'h0) begin errors++; $display("FAIL stale_redirect: got %b %h want 1 00000000", MispredictE, RedirectPCE); end
        checks++; if (PredTargetF !== 32'h0) begin errors++; $display("FAIL fetch_wrap: got %h want 00000000", PredTargetF); end
        tick(); drive_idle(); exp_miss++;
        PCF = 32'h140;
        #1;
        checks++; if (BranchCnt !== 16'(exp_br) || MissCnt !== 16'(exp_miss)) begin errors++; $display("FAIL stale_counters: got %0d/%0d want %0d/%0d", BranchCnt, MissCnt, exp_br, exp_miss); end
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h500) begin errors++; $display("FAIL stale_table_intact: got %b %h want 1 00000500", PredTakenF, PredTargetF); end
    endtask

    task automatic test_saturation();
        int want;
        #3;
        rst = 1'b0;
        #1;
        checks++; if (sat_branch_cnt !== 2'd0 || sat_miss_cnt !== 2'd0) begin errors++; $display("FAIL sat_reset: got %0d/%0d want 0/0", sat_branch_cnt, sat_miss_cnt); end
        checks++; if (sat_pred_taken !== 1'b0 || sat_pred_target !== 32'h144) begin errors++; $display("FAIL sat_reset_lookup: got %b %h want 0 00000144", sat_pred_taken, sat_pred_target); end
        rst = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            resolve(1'b0, 32'h100, 32'h0, 1'b1, 32'h200);
            #1;
            checks++; if (sat_mispredict !== 1'b1 || sat_redirect !== 32'h104) begin errors++; $display("FAIL sat_mispredict[%0d]: got %b %h want 1 00000104", k, sat_mispredict, sat_redirect); end
            tick();
            want = (k < 2) ? k + 1 : 3;
            checks++; if (sat_branch_cnt !== 2'(want) || sat_miss_cnt !== 2'(want)) begin errors++; $display("FAIL sat_count[%0d]: got %0d/%0d want %0d/%0d", k, sat_branch_cnt, sat_miss_cnt, want, want); end
        end
        drive_idle();
        #1;
        checks++; if (BranchCnt !== 16'd5 || MissCnt !== 16'd5) begin errors++; $display("FAIL wide_count: got %0d/%0d want 5/5", BranchCnt, MissCnt); end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        exp_br   = 0;
        exp_miss = 0;
        test_reset();
        test_cold_miss();
        test_hysteresis();
        test_aliasing();
        test_flush_stale();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
